semiauto_executor: RTL and testbench
====================================

# semiauto_executor

Registers the next-state / next-motion commands from the semi-auto decision logic into the current `state` / `moving_state` that feed back into that logic and drive the motor and indicator outputs. It also owns the turning phase: it times each left, right or U-turn and returns the car to waiting. It sits between the semi-auto decision block and the motor/light drivers.

## Interface
- CLK_HZ, 100_000_000: `sys_clk` frequency.
- TICK_MS, 20: timer tick period in ms. TICK_CYCLES = CLK_HZ/1000*TICK_MS.
- TURN_TICKS, 45: ticks for a 90° turn.
- AROUND_TICKS, 90: ticks for a U-turn.
- BLINK_TICKS, 25: ticks per half-period of the turn-light blink.
- sys_clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- power  in  1  car powered.
- global_state  in  2  mode select; 01 or 10 enables this block.
- next_state  in  2  requested state: 00 FORWARD, 01 WAIT, 10 TURN, 11 COOL.
- next_moving_state  in  4  requested motion: 0000 STOP, 0001 FORWARD, 0010 BACKWARD, 0100 LEFT, 1000 RIGHT.
- around_req  in  1  sampled on TURN entry; 1 selects U-turn duration.
- state  out  2  registered current state.
- moving_state  out  4  registered current motion; this is the motor command.
- turn_done  out  1  one-cycle pulse when a turn completes.
- move_forward_light, move_backward_light, turn_left_light, turn_right_light  out  1 each  indicators.

## Operation
- enable = power & (global_state==01 | global_state==10).
- enable=0 on any cycle:
  - Next edge forces state=WAIT and moving_state=STOP.
  - Clears turn counter, tick prescaler and blink phase.
  - No turn_done pulse, including when a turn is aborted.
- enable=1, state≠TURN:
  - state<=next_state and moving_state<=next_moving_state every cycle.
- Entry to TURN (state≠TURN, next_state==TURN) is valid only if next_moving_state is LEFT or RIGHT. A valid entry does the following in the same edge:
  - Latch turn_len = around_req ? AROUND_TICKS : TURN_TICKS.
  - Clear the prescaler and the turn counter.
  - Clear the blink phase to on.
- Invalid TURN request (any other motion): state<=WAIT, moving_state<=STOP.
- In TURN:
  - next_state and next_moving_state are ignored; moving_state is held.
  - turn_cnt increments on each tick.
  - On the tick that makes turn_cnt==turn_len: state<=WAIT, moving_state<=STOP, turn_done=1 for exactly that one cycle.
- Prescaler:
  - Counts 0..TICK_CYCLES-1; tick=1 on the terminal count.
  - Free-running outside TURN.
- turn_cnt and blink counter: 11-bit, saturate, never wrap.
- Lights:
  - forward = (moving_state==0001).
  - backward = (moving_state==0010).
  - left = state==TURN & moving_state==0100 & blink phase on.
  - right = same with 1000.
  - Blink phase toggles every BLINK_TICKS ticks.
  - All lights are 0 when enable=0.

## Timing
- Reset values: state=01 (WAIT), moving_state=0000, turn_done=0, all lights 0, all counters 0.
- Command-to-output latency: 1 cycle. Lights are combinational from the registered state.
- A turn lasts exactly turn_len*TICK_CYCLES cycles, counted from the entry edge to the exit edge.
- WAIT resumes in the cycle after turn_done. From then, next_state is accepted again on the following edge.
- Reset asserted mid-turn: outputs go to reset values immediately, with no turn_done.
- enable dropping on the same edge as turn completion: enable wins, so no turn_done.

## Test plan
Parameters for all scenarios: CLK_HZ=1000, TICK_MS=4 (TICK_CYCLES=4), TURN_TICKS=3, AROUND_TICKS=6, BLINK_TICKS=1.
- Reset released, enable=1, next=FORWARD/0001 -> one edge later state=00, moving_state=0001, move_forward_light=1.
- Turn: WAIT, then next=TURN/0100 with around_req=0 -> state=10 for exactly 12 cycles, then state=01 and moving_state=0000.
  - turn_done high for 1 cycle.
  - turn_left_light toggles every 4 cycles.
- U-turn: TURN/1000 with around_req=1 -> TURN lasts 24 cycles. Changing next_* mid-turn has no effect. turn_right_light blinks.
- Invalid request next=TURN/0001 -> state=01, moving_state=0000, no turn_done.
- power=0 at cycle 5 of a turn -> next edge state=01, moving_state=0000, all lights 0, no turn_done. A later turn still lasts the full 12 cycles.
- rst low mid-turn (asynchronous, not clock-aligned) -> outputs reset immediately. After release, behaviour matches the post-reset scenario.

Source files
------------

// File: rtl/semiauto_executor_if.sv
// semiauto_executor_if: command/status bundle between the semi-auto decision logic and the executor
interface semiauto_executor_if;
  logic       power;
  logic [1:0] global_state;
  logic [1:0] next_state;
  logic [3:0] next_moving_state;
  logic       around_req;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic       turn_done;
  logic       move_forward_light;
  logic       move_backward_light;
  logic       turn_left_light;
  logic       turn_right_light;
  modport master (
    output power, global_state, next_state, next_moving_state, around_req,
    input  state, moving_state, turn_done,
    input  move_forward_light, move_backward_light, turn_left_light, turn_right_light
  );
  modport slave (
    input  power, global_state, next_state, next_moving_state, around_req,
    output state, moving_state, turn_done,
    output move_forward_light, move_backward_light, turn_left_light, turn_right_light
  );
endinterface

// File: rtl/semiauto_executor.sv
// semiauto_executor: registers semi-auto state/motion commands and times turns with a blinking indicator
module semiauto_executor #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_MS      = 20,
  parameter int TURN_TICKS   = 45,
  parameter int AROUND_TICKS = 90,
  parameter int BLINK_TICKS  = 25
) (
  input logic                sys_clk,
  input logic                rst,
  semiauto_executor_if.slave bus
);
  localparam int TICK_CYCLES = CLK_HZ / 1000 * TICK_MS;
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [3:0] STOP = 4'b0000, FWD = 4'b0001, BACK = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;
  typedef enum logic [1:0] {FORWARD = 2'b00, WAIT = 2'b01, TURN = 2'b10, COOL = 2'b11} state_t;
  state_t      st;
  logic [3:0]  mv;
  logic [PW-1:0] presc;
  logic [10:0] turn_cnt, turn_len, blink_cnt;
  logic        phase;
  logic        enable, tick, in_turn, valid_dir, last_tick, blink_wrap;
  assign enable     = bus.power & (bus.global_state == 2'b01 | bus.global_state == 2'b10);
  assign tick       = presc == TICK_LAST;
  assign in_turn    = st == TURN;
  assign valid_dir  = bus.next_moving_state == LEFT | bus.next_moving_state == RIGHT;
  assign last_tick  = tick & ({1'b0, turn_cnt} + 12'd1 >= {1'b0, turn_len});
  assign blink_wrap = {1'b0, blink_cnt} + 12'd1 >= 12'(BLINK_TICKS);
  assign bus.state               = st;
  assign bus.moving_state        = mv;
  assign bus.turn_done           = enable & in_turn & last_tick;
  assign bus.move_forward_light  = enable & mv == FWD;
  assign bus.move_backward_light = enable & mv == BACK;
  assign bus.turn_left_light     = enable & in_turn & mv == LEFT & phase;
  assign bus.turn_right_light    = enable & in_turn & mv == RIGHT & phase;
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      st        <= WAIT;
      mv        <= STOP;
      presc     <= '0;
      turn_cnt  <= '0;
      turn_len  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!enable) begin
      st        <= WAIT;
      mv        <= STOP;
      presc     <= '0;
      turn_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (in_turn) begin
        if (tick) begin
          turn_cnt  <= &turn_cnt ? turn_cnt : turn_cnt + 11'd1;
          blink_cnt <= blink_wrap ? '0 : (&blink_cnt ? blink_cnt : blink_cnt + 11'd1);
          phase     <= phase ^ blink_wrap;
          if (last_tick) begin
            st <= WAIT;
            mv <= STOP;
          end
        end
      end else if (bus.next_state == TURN) begin
        // only a left/right motion can start a turn; anything else parks the car
        st <= valid_dir ? TURN : WAIT;
        mv <= valid_dir ? bus.next_moving_state : STOP;
        if (valid_dir) begin
          turn_len  <= bus.around_req ? 11'(AROUND_TICKS) : 11'(TURN_TICKS);
          presc     <= '0;
          turn_cnt  <= '0;
          blink_cnt <= '0;
          phase     <= 1'b1;
        end
      end else begin
        st <= state_t'(bus.next_state);
        mv <= bus.next_moving_state;
      end
    end
  end
endmodule

// File: tb/tb_semiauto_executor.sv
// tb_semiauto_executor: scoreboard bench; each driven cycle queues the outputs expected one edge later
module tb_semiauto_executor;
  localparam int TICK_CYCLES = 4;
  localparam int BLINK_TICKS = 1;
  localparam logic [1:0] S_FWD = 2'b00, S_WAIT = 2'b01, S_TURN = 2'b10;
  localparam logic [3:0] M_STOP = 4'b0000, M_FWD = 4'b0001, M_BACK = 4'b0010, M_LEFT = 4'b0100, M_RIGHT = 4'b1000;
  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] mv;
    logic       done;
    logic [3:0] lt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t cur;
  logic [3:0] moves [5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
  semiauto_executor_if bus ();
  semiauto_executor #(
    .CLK_HZ(1000), .TICK_MS(4), .TURN_TICKS(3), .AROUND_TICKS(6), .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .sys_clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t mk(input string tag, input logic [1:0] st, input logic [3:0] mv, input logic done, input logic [3:0] lt);
    exp_t e;
    e.tag = tag; e.st = st; e.mv = mv; e.done = done; e.lt = lt;
    return e;
  endfunction
  function automatic logic [3:0] lights();
    return {bus.move_forward_light, bus.move_backward_light, bus.turn_left_light, bus.turn_right_light};
  endfunction
  task automatic check_now(input exp_t e);
    check({e.tag, "_state"}, 32'(bus.state), 32'(e.st));
    check({e.tag, "_moving"}, 32'(bus.moving_state), 32'(e.mv));
    check({e.tag, "_done"}, 32'(bus.turn_done), 32'(e.done));
    check({e.tag, "_lights"}, 32'(lights()), 32'(e.lt));
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check_now(cur);
    end
  end
  task automatic cyc(input logic pw, input logic [1:0] gs, input logic [1:0] ns, input logic [3:0] nm, input logic ar, input exp_t e);
    @(negedge clk);
    #1;
    bus.power = pw;
    bus.global_state = gs;
    bus.next_state = ns;
    bus.next_moving_state = nm;
    bus.around_req = ar;
    sb.push_back(e);
  endtask
  task automatic do_turn(input logic [3:0] dir, input logic ar, input int ticks, input bit scramble, input int cut, input bit drop);
    int n = ticks * TICK_CYCLES;
    for (int k = 0; k <= n; k++) begin
      logic [1:0] ns;
      logic [3:0] nm;
      logic       ak;
      logic       on;
      if (k == cut && !drop) return;
      ns = k == 0 ? S_TURN : (scramble ? 2'($urandom_range(0, 3)) : S_WAIT);
      nm = k == 0 ? dir : (scramble ? moves[$urandom_range(0, 4)] : M_STOP);
      ak = k == 0 ? ar : (scramble ? 1'($urandom_range(0, 1)) : 1'b0);
      on = ((k / (TICK_CYCLES * BLINK_TICKS)) % 2) == 0;
      if (k == cut) begin
        cyc(1'b0, 2'b01, ns, nm, ak, mk("abort", S_WAIT, M_STOP, 1'b0, 4'b0000));
        return;
      end
      if (k == n) cyc(1'b1, 2'b01, ns, nm, ak, mk("turn_exit", S_WAIT, M_STOP, 1'b0, 4'b0000));
      else cyc(1'b1, 2'b01, ns, nm, ak, mk("turn", S_TURN, dir, k == n - 1, {2'b00, on & dir == M_LEFT, on & dir == M_RIGHT}));
    end
  endtask
  initial begin
    bus.power = 1'b1;
    bus.global_state = 2'b01;
    bus.next_state = S_WAIT;
    bus.next_moving_state = M_STOP;
    bus.around_req = 1'b0;
    #1 rst = 1'b0;
    #2 check_now(mk("reset", S_WAIT, M_STOP, 1'b0, 4'b0000));
    @(posedge clk);
    #1 check_now(mk("reset_hold", S_WAIT, M_STOP, 1'b0, 4'b0000));
    #16 rst = 1'b1;
    cyc(1, 2'b01, S_FWD, M_FWD, 0, mk("fwd", S_FWD, M_FWD, 1'b0, 4'b1000));
    cyc(1, 2'b10, S_FWD, M_BACK, 0, mk("back", S_FWD, M_BACK, 1'b0, 4'b0100));
    cyc(1, 2'b00, S_FWD, M_FWD, 0, mk("gs00", S_WAIT, M_STOP, 1'b0, 4'b0000));
    cyc(1, 2'b11, S_FWD, M_FWD, 0, mk("gs11", S_WAIT, M_STOP, 1'b0, 4'b0000));
    cyc(1, 2'b01, S_WAIT, M_STOP, 0, mk("wait", S_WAIT, M_STOP, 1'b0, 4'b0000));
    do_turn(M_LEFT, 1'b0, 3, 1'b0, -1, 1'b0);
    cyc(1, 2'b01, S_FWD, M_FWD, 0, mk("post_turn", S_FWD, M_FWD, 1'b0, 4'b1000));
    cyc(1, 2'b01, S_WAIT, M_STOP, 0, mk("wait2", S_WAIT, M_STOP, 1'b0, 4'b0000));
    do_turn(M_RIGHT, 1'b1, 6, 1'b1, -1, 1'b0);
    cyc(1, 2'b01, S_FWD, M_FWD, 0, mk("pre_bad", S_FWD, M_FWD, 1'b0, 4'b1000));
    cyc(1, 2'b01, S_TURN, M_FWD, 0, mk("bad_turn_fwd", S_WAIT, M_STOP, 1'b0, 4'b0000));
    cyc(1, 2'b01, S_FWD, M_BACK, 0, mk("pre_bad2", S_FWD, M_BACK, 1'b0, 4'b0100));
    cyc(1, 2'b01, S_TURN, M_STOP, 1, mk("bad_turn_stop", S_WAIT, M_STOP, 1'b0, 4'b0000));
    do_turn(M_LEFT, 1'b0, 3, 1'b0, 5, 1'b1);
    cyc(1, 2'b01, S_WAIT, M_STOP, 0, mk("repower", S_WAIT, M_STOP, 1'b0, 4'b0000));
    do_turn(M_LEFT, 1'b0, 3, 1'b0, -1, 1'b0);
    do_turn(M_RIGHT, 1'b1, 6, 1'b0, 23, 1'b1);
    cyc(1, 2'b01, S_WAIT, M_STOP, 0, mk("repower2", S_WAIT, M_STOP, 1'b0, 4'b0000));
    do_turn(M_RIGHT, 1'b0, 3, 1'b0, 6, 1'b0);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check_now(mk("async_reset", S_WAIT, M_STOP, 1'b0, 4'b0000));
    @(posedge clk);
    #2 check_now(mk("async_reset_hold", S_WAIT, M_STOP, 1'b0, 4'b0000));
    #4 rst = 1'b1;
    cyc(1, 2'b01, S_FWD, M_FWD, 0, mk("rst_fwd", S_FWD, M_FWD, 1'b0, 4'b1000));
    cyc(1, 2'b01, S_WAIT, M_STOP, 0, mk("rst_wait", S_WAIT, M_STOP, 1'b0, 4'b0000));
    do_turn(M_LEFT, 1'b0, 3, 1'b0, -1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
